// File: rtl/rr_arbiter32.sv
// Round-robin arbiter sharing one resource among 32 requesters.
// Grants are registered and held until done, withdraw or an optional hold timeout.
module rr_arbiter32 #(
    parameter logic [15:0] TIMEOUT = 16'd255
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic [31:0] iReq,
    input  logic        iDone,
    output logic [31:0] oGrant,
    output logic [4:0]  oGrantIdx,
    output logic        oBusy,
    output logic        oTimeout
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [15:0] TO_LAST = TIMEOUT - 16'd1;

    state_t      r_state, w_state_next;
    logic [4:0]  r_ptr, w_ptr_next;
    logic [15:0] r_cnt, w_cnt_next;
    logic [31:0] r_grant, w_grant_next;
    logic [4:0]  r_idx, w_idx_next;
    logic        r_busy, w_busy_next;
    logic        r_timeout, w_timeout_next;

    logic [31:0] w_rot;
    logic [4:0]  w_off;
    logic [4:0]  w_sel_idx;
    logic        w_release;

    // Requests rotated so that bit 0 is the current highest-priority requester.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_rot
            logic [4:0] w_pos;
            assign w_pos     = r_ptr + 5'(gi);
            assign w_rot[gi] = iReq[w_pos];
        end
    endgenerate

    always_comb begin
        w_off = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = 5'(i);
            end
        end
    end

    assign w_sel_idx = r_ptr + w_off;

    always_comb begin
        w_state_next   = r_state;
        w_ptr_next     = r_ptr;
        w_cnt_next     = r_cnt;
        w_grant_next   = r_grant;
        w_idx_next     = r_idx;
        w_busy_next    = r_busy;
        w_timeout_next = 1'b0;
        w_release      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (|iReq) begin
                    w_state_next = ST_BUSY;
                    w_idx_next   = w_sel_idx;
                    w_grant_next = 32'd1 << w_sel_idx;
                    w_busy_next  = 1'b1;
                    w_cnt_next   = 16'd0;
                end
            end
            ST_BUSY: begin
                // Done outranks withdraw, which outranks timeout.
                if (iDone) begin
                    w_release = 1'b1;
                end else if (!iReq[r_idx]) begin
                    w_release = 1'b1;
                end else if ((TIMEOUT != 16'd0) && (r_cnt == TO_LAST)) begin
                    w_release      = 1'b1;
                    w_timeout_next = 1'b1;
                end else if (r_cnt != 16'hFFFF) begin
                    w_cnt_next = r_cnt + 16'd1;
                end

                if (w_release) begin
                    w_state_next = ST_IDLE;
                    w_grant_next = 32'd0;
                    w_busy_next  = 1'b0;
                    w_ptr_next   = r_idx + 5'd1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= 5'd0;
            r_cnt     <= 16'd0;
            r_grant   <= 32'd0;
            r_idx     <= 5'd0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_ptr     <= w_ptr_next;
            r_cnt     <= w_cnt_next;
            r_grant   <= w_grant_next;
            r_idx     <= w_idx_next;
            r_busy    <= w_busy_next;
            r_timeout <= w_timeout_next;
        end
    end

    assign oGrant    = r_grant;
    assign oGrantIdx = r_idx;
    assign oBusy     = r_busy;
    assign oTimeout  = r_timeout;

endmodule

// File: tb/tb_rr_arbiter32.sv
// Self-checking bench for rr_arbiter32: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_rr_arbiter32;

    localparam logic [15:0] TO = 16'd4;

    logic        clk;
    logic        rst;
    logic [31:0] req;
    logic        done;
    logic [31:0] o_grant;
    logic [4:0]  o_idx;
    logic        o_busy;
    logic        o_to;

    int errors = 0;
    int checks = 0;

    // Reference model state: who holds the grant and for how many cycles.
    bit      m_busy;
    int      m_idx;
    int      m_ptr;
    int      m_held;
    bit      m_to;

    rr_arbiter32 #(.TIMEOUT(TO)) dut (
        .iClk      (clk),
        .iRst      (rst),
        .iReq      (req),
        .iDone     (done),
        .oGrant    (o_grant),
        .oGrantIdx (o_idx),
        .oBusy     (o_busy),
        .oTimeout  (o_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [38:0] model_out();
        logic [31:0] g;
        g = m_busy ? (32'd1 << m_idx) : 32'd0;
        return {g, 5'(m_idx), m_busy, m_to};
    endfunction

    // Advance one clock edge, update the model from the same inputs, sample 1ns later.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_busy = 0; m_idx = 0; m_ptr = 0; m_held = 0; m_to = 0;
        end else begin
            m_to = 0;
            if (!m_busy) begin
                if (req != 0) begin
                    for (int k = 0; k < 32; k++) begin
                        int j;
                        j = (m_ptr + k) % 32;
                        if (req[j]) begin
                            m_idx = j; m_busy = 1; m_held = 1;
                            break;
                        end
                    end
                end
            end else begin
                bit rel;
                rel = 0;
                if (done) rel = 1;
                else if (!req[m_idx]) rel = 1;
                else if (TO != 0 && m_held == int'(TO)) begin
                    rel = 1; m_to = 1;
                end else m_held++;
                if (rel) begin
                    m_busy = 0;
                    m_ptr = (m_idx + 1) % 32;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1; req = 32'hFFFF_FFFF; done = 0;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if ({o_grant, o_idx, o_busy, o_to} !== 39'd0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got %h want 0", c, {o_grant, o_idx, o_busy, o_to});
            end
        end
        rst = 0;
        tick();
        checks++;
        if (o_grant !== 32'h1 || o_busy !== 1'b1 || o_idx !== 5'd0) begin
            errors++;
            $display("FAIL reset_first_grant: got grant=%h idx=%0d busy=%b want grant=00000001 idx=0 busy=1", o_grant, o_idx, o_busy);
        end
        $display("reset: first grant idx=%0d", o_idx);
    endtask

    task automatic test_fairness();
        int exp_seq [6] = '{0, 4, 31, 0, 4, 31};
        rst = 1; req = 0; done = 0; tick(); rst = 0;
        req = 32'h8000_0011;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (o_busy !== 1'b1 || o_idx !== 5'(exp_seq[k]) || o_grant !== (32'd1 << exp_seq[k])) begin
                errors++;
                $display("FAIL fairness_grant %0d: got idx=%0d busy=%b want idx=%0d busy=1", k, o_idx, o_busy, exp_seq[k]);
            end
            $display("fairness: grant %0d idx=%0d", k, o_idx);
            done = 1;
            tick();
            done = 0;
            checks++;
            if (o_busy !== 1'b0 || o_grant !== 32'd0) begin
                errors++;
                $display("FAIL fairness_release %0d: got busy=%b grant=%h want busy=0 grant=0", k, o_busy, o_grant);
            end
        end
    endtask

    task automatic test_pointer_wrap();
        int exp_seq [2] = '{1, 2};
        req = 32'h0000_0006;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (o_busy !== 1'b1 || o_idx !== 5'(exp_seq[k])) begin
                errors++;
                $display("FAIL wrap_grant %0d: got idx=%0d busy=%b want idx=%0d busy=1", k, o_idx, o_busy, exp_seq[k]);
            end
            $display("wrap: grant idx=%0d", o_idx);
            done = 1; tick(); done = 0;
        end
        req = 0; tick();
    endtask

    task automatic test_withdraw();
        req = 32'd1 << 7;
        tick();
        checks++;
        if (o_idx !== 5'd7 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL withdraw_grant: got idx=%0d busy=%b want idx=7 busy=1", o_idx, o_busy);
        end
        tick(); tick();
        req = 0;
        tick();
        checks++;
        if (o_grant !== 32'd0 || o_busy !== 1'b0 || o_to !== 1'b0) begin
            errors++;
            $display("FAIL withdraw_release: got grant=%h busy=%b to=%b want 0/0/0", o_grant, o_busy, o_to);
        end
        // Pointer now 8: requester 8 must win over 3 and 7.
        req = (32'd1 << 7) | (32'd1 << 8) | (32'd1 << 3);
        tick();
        checks++;
        if (o_idx !== 5'd8) begin
            errors++;
            $display("FAIL withdraw_ptr: got idx=%0d want 8", o_idx);
        end
        $display("withdraw: next grant idx=%0d", o_idx);
        done = 1; tick(); done = 0;
        req = 0; tick();
    endtask

    task automatic test_timeout();
        int busy_cycles;
        req = 32'd1 << 5; done = 0;
        tick();
        busy_cycles = 0;
        for (int c = 0; c < 10 && o_busy; c++) begin
            busy_cycles++;
            tick();
        end
        checks++;
        if (busy_cycles != int'(TO) || o_to !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_hold: got busy_cycles=%0d to=%b busy=%b want %0d/1/0", busy_cycles, o_to, o_busy, TO);
        end
        $display("timeout: held %0d cycles, pulse=%b", busy_cycles, o_to);
        tick();
        checks++;
        if (o_to !== 1'b0 || o_busy !== 1'b1 || o_idx !== 5'd5) begin
            errors++;
            $display("FAIL timeout_regrant: got to=%b busy=%b idx=%0d want 0/1/5", o_to, o_busy, o_idx);
        end
        tick(); tick(); tick();
        done = 1;
        tick();
        done = 0;
        checks++;
        if (o_to !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_with_done: got to=%b busy=%b want 0/0", o_to, o_busy);
        end
        $display("timeout: done on timeout cycle, pulse=%b", o_to);
        req = 0; tick();
    endtask

    task automatic test_reset_mid_grant();
        req = 32'd1 << 20;
        tick();
        checks++;
        if (o_idx !== 5'd20 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_grant: got idx=%0d busy=%b want 20/1", o_idx, o_busy);
        end
        rst = 1;
        tick();
        checks++;
        if (o_grant !== 32'd0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_drop: got grant=%h busy=%b want 0/0", o_grant, o_busy);
        end
        rst = 0;
        req = 32'h0010_0001;
        tick();
        checks++;
        if (o_idx !== 5'd0 || o_grant !== 32'h1) begin
            errors++;
            $display("FAIL midreset_ptr: got idx=%0d grant=%h want 0/00000001", o_idx, o_grant);
        end
        $display("midreset: post-reset grant idx=%0d", o_idx);
        done = 1; tick(); done = 0;
    endtask

    task automatic test_random();
        int errs_before;
        errs_before = errors;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(2, 0) == 0) req = $urandom & $urandom & $urandom;
            done = ($urandom_range(4, 0) == 0);
            rst  = ($urandom_range(99, 0) == 0);
            tick();
            checks++;
            if ({o_grant, o_idx, o_busy, o_to} !== model_out()) begin
                errors++;
                $display("FAIL random cycle %0d: got %h want %h", c, {o_grant, o_idx, o_busy, o_to}, model_out());
            end
        end
        rst = 0; done = 0;
        $display("random: 600 cycles, %0d errors", errors - errs_before);
    endtask

    initial begin
        rst = 1; req = 0; done = 0;
        m_busy = 0; m_idx = 0; m_ptr = 0; m_held = 0; m_to = 0;
        test_reset();
        test_fairness();
        test_pointer_wrap();
        test_withdraw();
        test_timeout();
        test_reset_mid_grant();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
